wb_openram_port: RTL and testbench

WB_OPENRAM_PORT -- requirements
Module: wb_openram_port

---
 rtl/wb_openram_port.sv | 183 ++++++++++++++++++
 tb/tb_wb_openram_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_openram_port.sv
`default_nettype none
// ============================================================================
// Module      : wb_openram_port
// Description : Wishbone classic slave bridging to port 0 of an OpenRAM
//               single-port SRAM. A four-state FSM (IDLE/ISSUE/RDATA/ACK)
//               presents one registered SRAM access per request and returns
//               a single-cycle acknowledge. Writes take 2 cycles from the
//               first strobe cycle to ack, and reads take 3.
//               Optional macro WB_OPENRAM_ERR_EN adds wbs_err_o and an
//               address-window check. Without it, the window aliases.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_openram_port #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ADDR_WIDTH = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rstn_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
`ifdef WB_OPENRAM_ERR_EN
    output logic                  wbs_err_o,
`endif
    output logic                  csb0,
    output logic                  web0,
    output logic [3:0]            wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [31:0]           din0,
    input  logic [31:0]           dout0
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [3:0]            wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [31:0]           din0_q, din0_d;
    logic [31:0]           dat_o_q, dat_o_d;
    logic                  w_req;

    assign w_req = wbs_cyc_i & wbs_stb_i;

`ifdef WB_OPENRAM_ERR_EN
    // Window bounds widened to 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] C_WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] C_WIN_HI = C_WIN_LO + (33'd4 << ADDR_WIDTH);

    logic err_q, err_d;
    logic err_pend_q, err_pend_d;
    logic w_in_range;

    assign w_in_range = ({1'b0, wbs_adr_i} >= C_WIN_LO) && ({1'b0, wbs_adr_i} < C_WIN_HI);
    assign wbs_err_o  = err_q;
`else
    // Only the word-address bits select a location, so all other bits alias.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};
`endif

    // Next-state and next-output logic. Every output is registered.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        csb0_d   = 1'b1;
        web0_d   = web0_q;
        wmask0_d = wmask0_q;
        addr0_d  = addr0_q;
        din0_d   = din0_q;
        dat_o_d  = dat_o_q;
`ifdef WB_OPENRAM_ERR_EN
        err_d      = 1'b0;
        err_pend_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (w_req) begin
                    state_d  = ISSUE;
                    csb0_d   = 1'b0;
                    addr0_d  = wbs_adr_i[ADDR_WIDTH+1:2];
                    din0_d   = wbs_dat_i;
                    web0_d   = ~wbs_we_i;
                    wmask0_d = wbs_we_i ? wbs_sel_i : 4'h0;
`ifdef WB_OPENRAM_ERR_EN
                    // An out-of-window request keeps the SRAM deselected. It
                    // still spends one cycle before responding, so the error
                    // arrives with the same timing as a write ack.
                    if (!w_in_range) begin
                        csb0_d     = 1'b1;
                        err_pend_d = 1'b1;
                    end
`endif
                end
            end
            ISSUE: begin
                // A dropped cycle abandons the response only. The SRAM
                // access was already presented this cycle, so a write commits.
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
`ifdef WB_OPENRAM_ERR_EN
                end else if (err_pend_q) begin
                    state_d = ACK;
                    err_d   = 1'b1;
`endif
                end else if (!web0_q) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end else begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    dat_o_d = dout0;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= 4'h0;
            addr0_q  <= '0;
            din0_q   <= 32'h0;
            dat_o_q  <= 32'h0;
`ifdef WB_OPENRAM_ERR_EN
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            csb0_q   <= csb0_d;
            web0_q   <= web0_d;
            wmask0_q <= wmask0_d;
            addr0_q  <= addr0_d;
            din0_q   <= din0_d;
            dat_o_q  <= dat_o_d;
`ifdef WB_OPENRAM_ERR_EN
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign csb0      = csb0_q;
    assign web0      = web0_q;
    assign wmask0    = wmask0_q;
    assign addr0     = addr0_q;
    assign din0      = din0_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_openram_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_openram_port
// Description : Directed self-checking bench for wb_openram_port with a
//               behavioural OpenRAM port-0 model (registered on clk).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_openram_port;

    logic        clk;
    logic        rstn;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        err_w;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;

    logic [31:0] mem [0:255];

    int n_checks;
    int n_errors;

    int          x_lat, x_csb, x_acks;
    logic        x_web_low, x_ack, x_err;
    logic [7:0]  x_addr0;
    logic [3:0]  x_wmask0;

    wb_openram_port #(
        .BASE_ADDR  (32'h3000_0000),
        .ADDR_WIDTH (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
`ifdef WB_OPENRAM_ERR_EN
        .wbs_err_o (err_w),
`endif
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

`ifndef WB_OPENRAM_ERR_EN
    assign err_w = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // OpenRAM-style port 0: inputs captured on the rising edge, read data after it.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer, starting just after a rising edge. Records
    // latency in edges from the first strobe cycle to ack/err (0 = timeout).
    task automatic wb_xfer(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_w = d;
        x_lat = 0; x_csb = 0; x_web_low = 1'b0; x_ack = 1'b0; x_err = 1'b0;
        x_addr0 = 8'h0; x_wmask0 = 4'h0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (!csb0) begin
                x_csb++;
                x_addr0  = addr0;
                x_wmask0 = wmask0;
            end
            if (!web0) x_web_low = 1'b1;
            if (ack || err_w) begin
                x_lat = i; x_ack = ack; x_err = err_w;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        dout0 = 32'h0;
        cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        check("rst_ack",    {31'h0, ack},    32'h0);
        check("rst_dat_o",  dat_r,           32'h0);
        check("rst_csb0",   {31'h0, csb0},   32'h1);
        check("rst_web0",   {31'h0, web0},   32'h1);
        check("rst_wmask0", {28'h0, wmask0}, 32'h0);
        check("rst_addr0",  {24'h0, addr0},  32'h0);
        check("rst_din0",   din0,            32'h0);
        check("rst_err",    {31'h0, err_w},  32'h0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        // Full-word write.
        wb_xfer(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF);
        check("wr_lat",    x_lat,                2);
        check("wr_ack",    {31'h0, x_ack},       32'h1);
        check("wr_csb_n",  x_csb,                1);
        check("wr_addr0",  {24'h0, x_addr0},     32'h04);
        check("wr_wmask0", {28'h0, x_wmask0},    32'hF);
        check("wr_ack_1cy",{31'h0, ack},         32'h0);
        check("wr_dat_o",  dat_r,                32'h0);

        // Read back.
        wb_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        check("rd_lat",    x_lat,                3);
        check("rd_data",   dat_r,                32'hDEAD_BEEF);
        check("rd_web_hi", {31'h0, x_web_low},   32'h0);
        check("rd_csb_n",  x_csb,                1);

        // Byte-lane write, then read.
        wb_xfer(1'b1, 4'b0001, 32'h3000_0010, 32'h0000_00AA);
        check("bw_lat",    x_lat,                2);
        check("bw_dat_o",  dat_r,                32'hDEAD_BEEF);
        wb_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        check("bw_rd",     dat_r,                32'hDEAD_BEAA);

        // Write with no byte selects: acknowledged, memory unchanged.
        wb_xfer(1'b1, 4'h0, 32'h3000_0010, 32'hFFFF_FFFF);
        check("sel0_lat",  x_lat,                2);
        check("sel0_mask", {28'h0, x_wmask0},    32'h0);
        wb_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        check("sel0_rd",   dat_r,                32'hDEAD_BEAA);

`ifdef WB_OPENRAM_ERR_EN
        // Out-of-window read gives an error and never selects the SRAM.
        wb_xfer(1'b0, 4'hF, 32'h3000_0400, 32'h0);
        check("err_lat",   x_lat,                2);
        check("err_flag",  {31'h0, x_err},       32'h1);
        check("err_noack", {31'h0, x_ack},       32'h0);
        check("err_csb_n", x_csb,                0);
        check("err_1cy",   {31'h0, err_w},       32'h0);
`else
        // High address bits ignored: 0x7000_0410 aliases word 4.
        wb_xfer(1'b0, 4'hF, 32'h7000_0410, 32'h0);
        check("alias_lat", x_lat,                3);
        check("alias_rd",  dat_r,                32'hDEAD_BEAA);
`endif

        // Cycle dropped in RDATA: no ack, then a new read runs from IDLE.
        wb_xfer(1'b1, 4'hF, 32'h3000_0020, 32'h1234_5678);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0020;
        @(posedge clk); #1;
        check("ab_issue",  {31'h0, csb0},        32'h0);
        @(posedge clk); #1;
        check("ab_rdata",  {31'h0, ack},         32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("ab_noack",  {31'h0, ack},         32'h0);
        wb_xfer(1'b0, 4'hF, 32'h3000_0020, 32'h0);
        check("ab_rd_lat", x_lat,                3);
        check("ab_rd",     dat_r,                32'h1234_5678);

        // Reset pulsed during ISSUE of a read.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0010; dat_w = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("rr_issue",  {31'h0, csb0},        32'h0);
        check("rr_din0",   din0,                 32'hCAFE_F00D);
        #2 rstn = 1'b0;
        #1;
        check("rr_csb0",   {31'h0, csb0},        32'h1);
        check("rr_web0",   {31'h0, web0},        32'h1);
        check("rr_addr0",  {24'h0, addr0},       32'h0);
        check("rr_din0_0", din0,                 32'h0);
        check("rr_wmask0", {28'h0, wmask0},      32'h0);
        check("rr_dat_o",  dat_r,                32'h0);
        check("rr_ack",    {31'h0, ack},         32'h0);
        cyc = 1'b0; stb = 1'b0;
        #2 rstn = 1'b1;
        x_acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ack) x_acks++;
        end
        check("rr_noack",  x_acks,               0);
        wb_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        check("rr_rd_lat", x_lat,                3);
        check("rr_rd",     dat_r,                32'hDEAD_BEAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
